// File: rtl/apb_reg_responder.sv
// APB slave with four 32-bit registers; access phase is WAIT_STATES+2 cycles and PRDATA/PREADY/PSLVERR are registered.
// Defining APB_RESP_SLVERR_EN adds the PSLVERR error response for out-of-range transfers; otherwise PSLVERR is tied to 0.
module apb_reg_responder #(
  parameter int WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [1:0]  idx_q;
  logic        wr_q;
  logic        ok_q;
  logic [31:0] wdat_q;
  logic [31:0] regs [4];

  logic        live_ok;
  logic [1:0]  cur_idx;
  logic        cur_wr;
  logic        cur_ok;
  logic        go_ready;
  logic [31:0] rd_dat;
  logic        unused_paddr;

  assign unused_paddr = ^PADDR[31:12];
  assign live_ok = (PADDR[11:4] == 8'd0) && (PADDR[1:0] == 2'd0);

  // Leaving IDLE straight into READY must use the live bus; later, the captured copy.
  always_comb begin
    cur_idx = idx_q;
    cur_wr  = wr_q;
    cur_ok  = ok_q;
    if (state == ST_IDLE) begin
      cur_idx = PADDR[3:2];
      cur_wr  = PWRITE;
      cur_ok  = live_ok;
    end
  end

  assign go_ready = ((state == ST_IDLE) && PSEL && PENABLE && (WAIT_INIT == 4'd0)) ||
                    ((state == ST_WAIT) && PSEL && (cnt <= 4'd1));
  assign rd_dat   = (!cur_wr && cur_ok) ? regs[cur_idx] : 32'd0;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      idx_q  <= 2'd0;
      wr_q   <= 1'b0;
      ok_q   <= 1'b0;
      wdat_q <= 32'd0;
      PRDATA <= 32'd0;
      PREADY <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
    end else begin
      PREADY <= go_ready;
      PRDATA <= go_ready ? rd_dat : 32'd0;
      case (state)
        ST_IDLE: begin
          if (PSEL && PENABLE) begin
            idx_q  <= PADDR[3:2];
            wr_q   <= PWRITE;
            ok_q   <= live_ok;
            wdat_q <= PWDATA;
            if (WAIT_INIT == 4'd0) begin
              state <= ST_READY;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else if (cnt <= 4'd1) begin
            state <= ST_READY;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_READY: begin
          state <= ST_IDLE;
          if (wr_q && ok_q) regs[idx_q] <= wdat_q;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef APB_RESP_SLVERR_EN
  logic err_q;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= go_ready && !cur_ok;
    end
  end

  assign PSLVERR = err_q;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_responder.sv
// Bench for apb_reg_responder: three instances (WAIT_STATES 0, 1, 3) against a register-array reference model.
module tb_apb_reg_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  preset, psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr [3];
  logic [31:0] pwdata [3];
  logic [31:0] prdata [3];

  int checks = 0;
  int failures = 0;
  logic [31:0] mreg [3][4];
  int ws_of [3] = '{0, 1, 3};

  apb_reg_responder #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_reg_responder #(.WAIT_STATES(1)) u_ws1 (
    .PCLK(clk), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_reg_responder #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESET(preset[2]), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return ((a % 4096) < 16) && ((a % 4) == 0);
  endfunction

  function automatic int reg_idx(input logic [31:0] a);
    return int'((a % 16) / 4);
  endfunction

  function automatic logic [31:0] exp_err(input bit ok);
`ifdef APB_RESP_SLVERR_EN
    return ok ? 32'd0 : 32'd1;
`else
    return ok ? 32'd0 : 32'd0;
`endif
  endfunction

  // Entered and left at 1 time unit after a rising edge; leaves the bus idle.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input bit abort_it);
    int got_c;
    int hi;
    bit ok;
    logic [31:0] exp_rd;
    ok     = in_rng(addr);
    exp_rd = (!wr && ok) ? mreg[k][reg_idx(addr)] : 32'd0;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = data;
    @(negedge clk);
    check_eq("setup_ready", 32'(pready[k]), 0);
    @(posedge clk); #1 penable[k] = 1'b1;
    got_c = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (pready[k]) begin
        got_c = c;
        break;
      end
      check_eq("wait_rdata", prdata[k], 0);
      @(posedge clk); #1;
      paddr[k]  = $urandom;
      pwdata[k] = $urandom;
      if (abort_it) begin
        psel[k] = 1'b0; penable[k] = 1'b0;
        hi = 0;
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          if (pready[k]) hi++;
          @(posedge clk); #1;
        end
        check_eq("abort_no_ready", hi, 0);
        return;
      end
    end
    check_eq("ready_cycle", got_c, ws_of[k] + 2);
    check_eq("rdata", prdata[k], exp_rd);
    check_eq("slverr", 32'(pslverr[k]), exp_err(ok));
    if (got_c != 0 && wr && ok) mreg[k][reg_idx(addr)] = data;
    @(posedge clk); #1 psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    int k;
    bit wr, ab;
    logic [31:0] addr;

    preset = '0; psel = '0; penable = '0; pwrite = '0;
    for (int i = 0; i < 3; i++) begin
      paddr[i] = '0; pwdata[i] = '0;
      for (int j = 0; j < 4; j++) mreg[i][j] = '0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_rdata", prdata[i], 0);
      check_eq("rst_ready", 32'(pready[i]), 0);
      check_eq("rst_slverr", 32'(pslverr[i]), 0);
    end
    repeat (3) @(posedge clk);
    #1 preset = '1;
    idle_cycles(2);

    // four registers, WAIT_STATES=1
    for (int i = 0; i < 4; i++) xfer(1, 1'b1, 32'h1000_0000 + 32'(4 * i), 32'(10 + i), 1'b0);
    for (int i = 0; i < 4; i++) xfer(1, 1'b0, 32'h1000_0000 + 32'(4 * i), 32'd0, 1'b0);
    idle_cycles(1);

    xfer(0, 1'b0, 32'h1000_0000, 32'd0, 1'b0);
    xfer(2, 1'b0, 32'h1000_0000, 32'd0, 1'b0);

    xfer(1, 1'b1, 32'h1000_0010, 32'h55, 1'b0);
    xfer(1, 1'b0, 32'h1000_0000, 32'd0, 1'b0);

    xfer(2, 1'b1, 32'h1000_0004, 32'hAA, 1'b1);
    xfer(2, 1'b0, 32'h1000_0004, 32'd0, 1'b0);

    // back-to-back, no idle cycle
    xfer(1, 1'b1, 32'h1000_000C, 32'd7, 1'b0);
    xfer(1, 1'b0, 32'h1000_000C, 32'd0, 1'b0);

    // reset during WAIT of a write; REG2 held 0x33 beforehand
    xfer(2, 1'b1, 32'h1000_0008, 32'h33, 1'b0);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h1000_0008; pwdata[2] = 32'hFF;
    @(posedge clk); #1 penable[2] = 1'b1;
    @(posedge clk); #1 preset[2] = 1'b0;
    #1;
    check_eq("midrst_rdata", prdata[2], 0);
    check_eq("midrst_ready", 32'(pready[2]), 0);
    check_eq("midrst_slverr", 32'(pslverr[2]), 0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int j = 0; j < 4; j++) mreg[2][j] = '0;
    @(posedge clk); #1 preset[2] = 1'b1;
    idle_cycles(1);
    xfer(2, 1'b0, 32'h1000_0008, 32'd0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 2);
      wr = 1'($urandom % 2);
      r  = $urandom;
      if ($urandom % 5 == 0) addr = $urandom;
      else addr = (r & 32'hFFFF_F000) | 32'($urandom_range(0, 3) * 4);
      ab = (k > 0) && ($urandom % 6 == 0);
      xfer(k, wr, addr, $urandom, ab);
      if ($urandom % 2 == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
